// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control sequencer: fetch/decode/execute/memory/write-back
// states driving every datapath select and enable, stalling on MReady.
module multicycle_ctrl_fsm #(
   parameter bit         MEM_WAIT_EN = 1'b1,
   parameter logic [5:0] OP_RTYPE    = 6'b000000,
   parameter logic [5:0] OP_LW       = 6'b100011,
   parameter logic [5:0] OP_SW       = 6'b101011,
   parameter logic [5:0] OP_BEQ      = 6'b000100,
   parameter logic [5:0] OP_ADDI     = 6'b001000,
   parameter logic [5:0] OP_J        = 6'b000010
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] UIn,
   input  logic       MReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MRead,
   output logic       MWrite,
   output logic       IRWrite,
   output logic       MtoR,
   output logic [1:0] PCSrc,
   output logic [2:0] AOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       Urw,
   output logic       RegDs,
   output logic       Done,
   output logic       Illegal,
   output logic [3:0] State
);

   localparam logic [3:0] FETCH  = 4'd0;
   localparam logic [3:0] DECODE = 4'd1;
   localparam logic [3:0] MEMADR = 4'd2;
   localparam logic [3:0] MEMRD  = 4'd3;
   localparam logic [3:0] MEMWB  = 4'd4;
   localparam logic [3:0] MEMWR  = 4'd5;
   localparam logic [3:0] EXEC   = 4'd6;
   localparam logic [3:0] RWB    = 4'd7;
   localparam logic [3:0] BRANCH = 4'd8;
   localparam logic [3:0] ADDIEX = 4'd9;
   localparam logic [3:0] ADDIWB = 4'd10;
   localparam logic [3:0] JUMP   = 4'd11;

   logic [3:0] state, next;
   logic [5:0] op_q;
   logic       ready;
   logic       is_mem, is_r, is_beq, is_addi, is_j;

   assign ready   = MEM_WAIT_EN ? MReady : 1'b1;
   assign is_mem  = (UIn == OP_LW) || (UIn == OP_SW);
   assign is_r    = (UIn == OP_RTYPE);
   assign is_beq  = (UIn == OP_BEQ);
   assign is_addi = (UIn == OP_ADDI);
   assign is_j    = (UIn == OP_J);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         op_q  <= '0;
      end else begin
         state <= next;
         if (state == DECODE) op_q <= UIn;
      end
   end

   always_comb begin
      next = FETCH;
      unique case (state)
         FETCH:  next = ready ? DECODE : FETCH;
         DECODE: begin
            unique case (1'b1)
               is_mem:  next = MEMADR;
               is_r:    next = EXEC;
               is_beq:  next = BRANCH;
               is_addi: next = ADDIEX;
               is_j:    next = JUMP;
               default: next = FETCH;
            endcase
         end
         MEMADR: next = (op_q == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  next = ready ? MEMWB : MEMRD;
         MEMWR:  next = ready ? FETCH : MEMWR;
         EXEC:   next = RWB;
         ADDIEX: next = ADDIWB;
         default: next = FETCH;
      endcase
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MRead       = 1'b0;
      MWrite      = 1'b0;
      IRWrite     = 1'b0;
      MtoR        = 1'b0;
      PCSrc       = 2'b00;
      AOp         = 3'b000;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      Urw         = 1'b0;
      RegDs       = 1'b0;
      Done        = 1'b0;
      Illegal     = 1'b0;
      unique case (state)
         FETCH: begin
            MRead   = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = ready;
            PCWrite = ready;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            Illegal = !(is_mem || is_r || is_beq || is_addi || is_j);
         end
         MEMADR, ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD: begin
            MRead = 1'b1;
            IorD  = 1'b1;
         end
         MEMWB: begin
            Urw  = 1'b1;
            MtoR = 1'b1;
            Done = 1'b1;
         end
         MEMWR: begin
            MWrite = 1'b1;
            IorD   = 1'b1;
            Done   = ready;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            AOp     = 3'b010;
         end
         RWB: begin
            Urw   = 1'b1;
            RegDs = 1'b1;
            Done  = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            AOp         = 3'b001;
            PCWriteCond = 1'b1;
            PCSrc       = 2'b01;
            Done        = 1'b1;
         end
         ADDIWB: begin
            Urw  = 1'b1;
            Done = 1'b1;
         end
         JUMP: begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
            Done    = 1'b1;
         end
         default: ;
      endcase
      // reset masks every control line so no enable can glitch high
      if (!rst_n) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MRead       = 1'b0;
         MWrite      = 1'b0;
         IRWrite     = 1'b0;
         MtoR        = 1'b0;
         PCSrc       = 2'b00;
         AOp         = 3'b000;
         ALUSrcA     = 1'b0;
         ALUSrcB     = 2'b00;
         Urw         = 1'b0;
         RegDs       = 1'b0;
         Done        = 1'b0;
         Illegal     = 1'b0;
      end
   end

   assign State = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: each step checks State plus all
// control outputs against hand-written per-state vectors.
module tb_multicycle_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] UIn;
   logic       MReady;
   logic       PCWrite, PCWriteCond, IorD, MRead, MWrite, IRWrite, MtoR;
   logic [1:0] PCSrc;
   logic [2:0] AOp;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       Urw, RegDs, Done, Illegal;
   logic [3:0] State;

   int nvec = 0;
   int nerr = 0;

   multicycle_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .UIn(UIn), .MReady(MReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MRead(MRead), .MWrite(MWrite), .IRWrite(IRWrite), .MtoR(MtoR),
      .PCSrc(PCSrc), .AOp(AOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .Urw(Urw), .RegDs(RegDs), .Done(Done), .Illegal(Illegal),
      .State(State)
   );

   always #5 clk = ~clk;

   // {PCWrite,PCWriteCond,IorD,MRead,MWrite,IRWrite,MtoR,PCSrc,AOp,
   //  ALUSrcA,ALUSrcB,Urw,RegDs,Done,Illegal}
   localparam logic [18:0] V_ZERO   = 19'b0;
   localparam logic [18:0] V_FET_W  = {7'b0001000, 2'b00, 3'b000, 1'b0, 2'b01, 4'b0000};
   localparam logic [18:0] V_FET_R  = {7'b1001010, 2'b00, 3'b000, 1'b0, 2'b01, 4'b0000};
   localparam logic [18:0] V_DEC    = {7'b0000000, 2'b00, 3'b000, 1'b0, 2'b11, 4'b0000};
   localparam logic [18:0] V_DEC_IL = {7'b0000000, 2'b00, 3'b000, 1'b0, 2'b11, 4'b0001};
   localparam logic [18:0] V_MADR   = {7'b0000000, 2'b00, 3'b000, 1'b1, 2'b10, 4'b0000};
   localparam logic [18:0] V_MRD    = {7'b0011000, 2'b00, 3'b000, 1'b0, 2'b00, 4'b0000};
   localparam logic [18:0] V_MWB    = {7'b0000001, 2'b00, 3'b000, 1'b0, 2'b00, 4'b1010};
   localparam logic [18:0] V_MWR_W  = {7'b0010100, 2'b00, 3'b000, 1'b0, 2'b00, 4'b0000};
   localparam logic [18:0] V_MWR_R  = {7'b0010100, 2'b00, 3'b000, 1'b0, 2'b00, 4'b0010};
   localparam logic [18:0] V_EXEC   = {7'b0000000, 2'b00, 3'b010, 1'b1, 2'b00, 4'b0000};
   localparam logic [18:0] V_RWB    = {7'b0000000, 2'b00, 3'b000, 1'b0, 2'b00, 4'b1110};
   localparam logic [18:0] V_BR     = {7'b0100000, 2'b01, 3'b001, 1'b1, 2'b00, 4'b0010};
   localparam logic [18:0] V_AWB    = {7'b0000000, 2'b00, 3'b000, 1'b0, 2'b00, 4'b1010};
   localparam logic [18:0] V_JMP    = {7'b1000000, 2'b10, 3'b000, 1'b0, 2'b00, 4'b0010};

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JJ = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   function automatic logic [22:0] obs();
      return {State, PCWrite, PCWriteCond, IorD, MRead, MWrite, IRWrite,
              MtoR, PCSrc, AOp, ALUSrcA, ALUSrcB, Urw, RegDs, Done, Illegal};
   endfunction

   task automatic check(input string tag, input logic [3:0] es,
                        input logic [18:0] ev);
      logic [22:0] o;
      o = obs();
      nvec++;
      assert (o === {es, ev}) else begin
         nerr++;
         $error("FAIL %s: state/outs got %h/%b expected %h/%b",
                tag, o[22:19], o[18:0], es, ev);
      end
   endtask

   // drive at negedge, check mid-low-phase, advance to next negedge
   task automatic step(input string tag, input logic mr, input logic [5:0] u,
                       input logic [3:0] es, input logic [18:0] ev);
      MReady = mr;
      UIn    = u;
      #1;
      check(tag, es, ev);
      @(negedge clk);
   endtask

   initial begin
      rst_n  = 1'b0;
      MReady = 1'b1;
      UIn    = RT;
      #1 check("reset_async", 4'd0, V_ZERO);
      @(negedge clk);
      @(negedge clk);
      check("reset_held", 4'd0, V_ZERO);
      rst_n = 1'b1;

      step("rt_fetch", 1'b1, RT, 4'd0, V_FET_R);
      step("rt_decode", 1'b1, RT, 4'd1, V_DEC);
      step("rt_exec", 1'b1, BAD, 4'd6, V_EXEC);
      step("rt_wb", 1'b1, BAD, 4'd7, V_RWB);

      step("lw_fetch_w1", 1'b0, BAD, 4'd0, V_FET_W);
      step("lw_fetch_w2", 1'b0, BAD, 4'd0, V_FET_W);
      step("lw_fetch", 1'b1, BAD, 4'd0, V_FET_R);
      step("lw_decode", 1'b1, LW, 4'd1, V_DEC);
      step("lw_memadr", 1'b1, SW, 4'd2, V_MADR);
      step("lw_memrd_w1", 1'b0, SW, 4'd3, V_MRD);
      step("lw_memrd_w2", 1'b0, SW, 4'd3, V_MRD);
      step("lw_memrd_w3", 1'b0, SW, 4'd3, V_MRD);
      step("lw_memrd", 1'b1, SW, 4'd3, V_MRD);
      step("lw_memwb", 1'b1, SW, 4'd4, V_MWB);

      step("sw_fetch", 1'b1, RT, 4'd0, V_FET_R);
      step("sw_decode", 1'b1, SW, 4'd1, V_DEC);
      step("sw_memadr", 1'b1, LW, 4'd2, V_MADR);
      step("sw_memwr", 1'b1, LW, 4'd5, V_MWR_R);

      step("beq_fetch", 1'b1, RT, 4'd0, V_FET_R);
      step("beq_decode", 1'b1, BEQ, 4'd1, V_DEC);
      step("beq_branch", 1'b1, RT, 4'd8, V_BR);
      step("j_fetch", 1'b1, RT, 4'd0, V_FET_R);
      step("j_decode", 1'b1, JJ, 4'd1, V_DEC);
      step("j_jump", 1'b1, RT, 4'd11, V_JMP);

      step("addi_fetch", 1'b1, RT, 4'd0, V_FET_R);
      step("addi_decode", 1'b1, ADDI, 4'd1, V_DEC);
      step("addi_ex", 1'b1, RT, 4'd9, V_MADR);
      step("addi_wb", 1'b1, RT, 4'd10, V_AWB);

      step("ill_fetch", 1'b1, RT, 4'd0, V_FET_R);
      step("ill_decode", 1'b1, BAD, 4'd1, V_DEC_IL);
      step("ill_refetch", 1'b0, BAD, 4'd0, V_FET_W);

      step("rst_fetch", 1'b1, RT, 4'd0, V_FET_R);
      step("rst_decode", 1'b1, SW, 4'd1, V_DEC);
      step("rst_memadr", 1'b1, SW, 4'd2, V_MADR);
      step("rst_memwr_w1", 1'b0, SW, 4'd5, V_MWR_W);
      MReady = 1'b0;
      #1 check("rst_memwr_w2", 4'd5, V_MWR_W);
      rst_n = 1'b0;
      #1 check("rst_mid_memwr", 4'd0, V_ZERO);
      @(negedge clk);
      check("rst_mid_held", 4'd0, V_ZERO);
      rst_n = 1'b1;
      step("post_fetch", 1'b1, RT, 4'd0, V_FET_R);
      step("post_decode", 1'b1, RT, 4'd1, V_DEC);
      step("post_exec", 1'b1, RT, 4'd6, V_EXEC);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
